// File: rtl/prova_match_engine_if.sv
// Stream, configuration and status signals of prova_match_engine.
// slave: the engine side; master: the producer/consumer side.
interface prova_match_engine_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
);
    logic                 cfg_we;
    logic [2*WIDTH-1:0]   cfg_rule;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic                 out_ready;
    logic                 match;
    logic [CNT_W-1:0]     match_cnt;
    logic                 alarm;
    logic                 clr_cnt;
    logic                 clr_alarm;

    modport slave (
        input  cfg_we, cfg_rule, in_valid, A, B, out_ready, clr_cnt, clr_alarm,
        output in_ready, out_valid, match, match_cnt, alarm
    );

    modport master (
        output cfg_we, cfg_rule, in_valid, A, B, out_ready, clr_cnt, clr_alarm,
        input  in_ready, out_valid, match, match_cnt, alarm
    );
endinterface

// File: rtl/prova_match_engine.sv
// Two-stage per-bit rule comparator with match counter and run-length alarm.
// Define PROVA_STICKY_ALARM_EN to make the alarm sticky until clr_alarm.
module prova_match_engine #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RUN_THRESH = 4
) (
    input logic                  clk,
    input logic                  rst,
    prova_match_engine_if.slave  bus
);
    localparam int unsigned      RULE_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_THRESH);

    // Legacy pattern: bit 0 AND, top bit OR, other odd bits NE, other even bits EQ.
    function automatic logic [RULE_W-1:0] legacy_rules();
        logic [RULE_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i == 0)                   v[2*i +: 2] = 2'b10;
            else if (i == int'(WIDTH) - 1) v[2*i +: 2] = 2'b11;
            else if ((i % 2) == 1)        v[2*i +: 2] = 2'b01;
            else                          v[2*i +: 2] = 2'b00;
        end
        return v;
    endfunction

    localparam logic [RULE_W-1:0] LEGACY_RULES = legacy_rules();

    logic [RULE_W-1:0] r_rule;
    logic              r_s1_valid;
    logic [WIDTH-1:0]  r_s1_pass;
    logic              r_out_valid;
    logic              r_match;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0]  r_run_len;
    logic              r_alarm;

    logic              w_adv;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_pass;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_run_nxt;
    logic              w_alarm_nxt;

    assign w_adv  = ~r_out_valid | bus.out_ready;
    assign w_xfer = r_out_valid & bus.out_ready;

    always_comb begin
        w_pass = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            unique case (r_rule[2*i +: 2])
                2'b00: w_pass[i] = ~(bus.A[i] ^ bus.B[i]);
                2'b01: w_pass[i] =   bus.A[i] ^ bus.B[i];
                2'b10: w_pass[i] =   bus.A[i] & bus.B[i];
                2'b11: w_pass[i] =   bus.A[i] | bus.B[i];
            endcase
        end
    end

    // Clear beats a coincident transfer; both counters saturate.
    always_comb begin
        w_cnt_nxt = r_match_cnt;
        w_run_nxt = r_run_len;
        if (bus.clr_cnt) begin
            w_cnt_nxt = '0;
            w_run_nxt = '0;
        end else if (w_xfer) begin
            if (r_match) begin
                if (r_match_cnt != CNT_MAX) w_cnt_nxt = r_match_cnt + CNT_W'(1);
                if (r_run_len != CNT_MAX)   w_run_nxt = r_run_len + CNT_W'(1);
            end else begin
                w_run_nxt = '0;
            end
        end
    end

`ifdef PROVA_STICKY_ALARM_EN
    always_comb begin
        w_alarm_nxt = r_alarm;
        if (w_xfer && r_match && !bus.clr_cnt && (w_run_nxt >= THRESH)) w_alarm_nxt = 1'b1;
        else if (bus.clr_alarm)                                          w_alarm_nxt = 1'b0;
    end
`else
    logic w_unused_clr_alarm;
    assign w_unused_clr_alarm = bus.clr_alarm;
    assign w_alarm_nxt        = (w_run_nxt >= THRESH);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rule      <= LEGACY_RULES;
            r_s1_valid  <= 1'b0;
            r_s1_pass   <= '0;
            r_out_valid <= 1'b0;
            r_match     <= 1'b0;
            r_match_cnt <= '0;
            r_run_len   <= '0;
            r_alarm     <= 1'b0;
        end else begin
            if (bus.cfg_we) r_rule <= bus.cfg_rule;
            if (w_adv) begin
                r_s1_valid  <= bus.in_valid;
                r_s1_pass   <= w_pass;
                r_out_valid <= r_s1_valid;
                r_match     <= &r_s1_pass;
            end
            r_match_cnt <= w_cnt_nxt;
            r_run_len   <= w_run_nxt;
            r_alarm     <= w_alarm_nxt;
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.match     = r_match;
    assign bus.match_cnt = r_match_cnt;
    assign bus.alarm     = r_alarm;
endmodule

// File: tb/tb_prova_match_engine.sv
// Bench for prova_match_engine: vector table, scoreboard and multi-cycle corner sequences.
module tb_prova_match_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prova_match_engine_if #(.WIDTH(16), .CNT_W(8)) d_if ();
    prova_match_engine_if #(.WIDTH(16), .CNT_W(2)) s_if ();

    prova_match_engine #(.WIDTH(16), .CNT_W(8), .RUN_THRESH(4)) u_dut (
        .clk(clk), .rst(rst), .bus(d_if));
    prova_match_engine #(.WIDTH(16), .CNT_W(2), .RUN_THRESH(3)) u_sat (
        .clk(clk), .rst(rst), .bus(s_if));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        we;
        logic [31:0] rule;
        bit          exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    bit sb[$];
    int m_cnt = 0;
    int m_run = 0;
    bit m_alarm = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_match(input logic [31:0] rule, input logic [15:0] a,
                                       input logic [15:0] b);
        bit ok;
        for (int i = 0; i < 16; i++) begin
            case (rule[2*i +: 2])
                2'b00:   ok = (a[i] == b[i]);
                2'b01:   ok = (a[i] != b[i]);
                2'b10:   ok = a[i] & b[i];
                default: ok = a[i] | b[i];
            endcase
            if (!ok) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Scoreboard and counter/alarm model, evaluated mid-cycle.
    always @(negedge clk) begin
        int run_n;
        bit xfer;
        bit mt;
        chk("match_cnt", 32'(d_if.match_cnt), 32'(m_cnt));
        chk("alarm", 32'(d_if.alarm), 32'(m_alarm));
        if (rst) begin
            sb.delete();
            m_cnt   = 0;
            m_run   = 0;
            m_alarm = 1'b0;
        end else begin
            xfer = d_if.out_valid && d_if.out_ready;
            mt   = 1'b0;
            if (xfer) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: out_valid=1 with no pair outstanding at %0t", $time);
                end else begin
                    mt = sb.pop_front();
                    chk("match", 32'(d_if.match), 32'(mt));
                end
            end
            if (d_if.clr_cnt) begin
                m_cnt = 0;
                run_n = 0;
            end else if (xfer && mt) begin
                if (m_cnt < 255) m_cnt++;
                run_n = (m_run < 255) ? m_run + 1 : 255;
            end else if (xfer) begin
                run_n = 0;
            end else begin
                run_n = m_run;
            end
`ifdef PROVA_STICKY_ALARM_EN
            if (xfer && mt && !d_if.clr_cnt && run_n >= 4) m_alarm = 1'b1;
            else if (d_if.clr_alarm)                      m_alarm = 1'b0;
`else
            m_alarm = (run_n >= 4);
`endif
            m_run = run_n;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic we,
                        input logic [31:0] rule, input bit exp);
        int budget;
        d_if.A = a;
        d_if.B = b;
        d_if.in_valid = 1'b1;
        d_if.cfg_we = we;
        d_if.cfg_rule = rule;
        budget = 0;
        @(negedge clk);
        while (!d_if.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!d_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 after 50 cycles, expected 1");
        end else begin
            sb.push_back(exp);
        end
        @(posedge clk); #1;
        d_if.in_valid = 1'b0;
        d_if.cfg_we = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        logic [15:0] ra, rb;
        logic [15:0] st_a[3];
        logic [15:0] st_b[3];
        bit          st_e[3];
        int acc;

        vecs[0]  = '{16'h8001, 16'h8001, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{16'hAAAB, 16'h8001, 1'b0, 32'h0,         1'b1};
        vecs[2]  = '{16'h1234, 16'h1234, 1'b1, 32'h0000_0000, 1'b0};
        vecs[3]  = '{16'h1234, 16'h1234, 1'b0, 32'h0,         1'b1};
        vecs[4]  = '{16'h0000, 16'hFFFF, 1'b0, 32'h0,         1'b0};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hAAAA_AAAA, 1'b1};
        vecs[6]  = '{16'hFFFF, 16'hFFFE, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'h0,         1'b1};
        vecs[8]  = '{16'h0001, 16'h0000, 1'b1, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{16'h0001, 16'hFFFE, 1'b0, 32'h0,         1'b1};
        vecs[10] = '{16'h0000, 16'h0000, 1'b0, 32'h0,         1'b0};
        vecs[11] = '{16'h0F0F, 16'hF0F0, 1'b1, 32'h5555_5555, 1'b1};
        vecs[12] = '{16'h0F0F, 16'hF0F0, 1'b0, 32'h0,         1'b1};
        vecs[13] = '{16'h0F0F, 16'hF0FF, 1'b0, 32'h0,         1'b0};

        d_if.cfg_we = 1'b0; d_if.cfg_rule = '0; d_if.in_valid = 1'b0;
        d_if.A = '0; d_if.B = '0; d_if.out_ready = 1'b1;
        d_if.clr_cnt = 1'b0; d_if.clr_alarm = 1'b0;
        s_if.cfg_we = 1'b0; s_if.cfg_rule = '0; s_if.in_valid = 1'b0;
        s_if.A = '0; s_if.B = '0; s_if.out_ready = 1'b1;
        s_if.clr_cnt = 1'b0; s_if.clr_alarm = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(d_if.out_valid), 32'd0);
        chk("rst_in_ready", 32'(d_if.in_ready), 32'd1);
        chk("rst_match", 32'(d_if.match), 32'd0);
        chk("rst_sat_cnt", 32'(s_if.match_cnt), 32'd0);

        // Two-cycle latency from accept to out_valid.
        send(16'h8001, 16'h8001, 1'b0, 32'h0, 1'b0);
        chk("lat_edge1", 32'(d_if.out_valid), 32'd0);
        cycles(1);
        chk("lat_edge2", 32'(d_if.out_valid), 32'd1);
        cycles(3);

        for (int i = 0; i < 14; i++) send(vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].rule, vecs[i].exp);
        cycles(4);
        chk("cnt_after_table", 32'(d_if.match_cnt), 32'd7);

        // Run of five matches then a mismatch; rules are all NE here.
        d_if.clr_cnt = 1'b1; cycles(1); d_if.clr_cnt = 1'b0;
        chk("cnt_cleared", 32'(d_if.match_cnt), 32'd0);
        for (int i = 0; i < 5; i++) send(16'h0F0F, 16'hF0F0, 1'b0, 32'h0, 1'b1);
        send(16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0);
        cycles(4);
        chk("run_cnt", 32'(d_if.match_cnt), 32'd5);
`ifdef PROVA_STICKY_ALARM_EN
        chk("alarm_after_mismatch", 32'(d_if.alarm), 32'd1);
`else
        chk("alarm_after_mismatch", 32'(d_if.alarm), 32'd0);
`endif
        d_if.clr_alarm = 1'b1; cycles(1); d_if.clr_alarm = 1'b0;
        chk("alarm_after_clr", 32'(d_if.alarm), 32'd0);

        // Backpressure: three pairs offered while out_ready is low.
        st_a = '{16'h0F0F, 16'h0000, 16'h0F0F};
        st_b = '{16'hF0F0, 16'h0000, 16'hF0F0};
        st_e = '{1'b1, 1'b0, 1'b1};
        acc = 0;
        d_if.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            d_if.A = st_a[acc]; d_if.B = st_b[acc]; d_if.in_valid = 1'b1;
            @(negedge clk);
            if (d_if.in_ready) begin
                sb.push_back(st_e[acc]);
                acc++;
            end
            @(posedge clk); #1;
        end
        d_if.in_valid = 1'b0;
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_in_ready", 32'(d_if.in_ready), 32'd0);
        chk("stall_out_valid", 32'(d_if.out_valid), 32'd1);
        cycles(2);
        chk("stall_hold_valid", 32'(d_if.out_valid), 32'd1);
        chk("stall_hold_match", 32'(d_if.match), 32'd1);
        d_if.out_ready = 1'b1;
        send(st_a[2], st_b[2], 1'b0, 32'h0, st_e[2]);
        cycles(4);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with pairs in flight; rules return to legacy.
        d_if.A = 16'h0F0F; d_if.B = 16'hF0F0; d_if.in_valid = 1'b1;
        cycles(2);
        d_if.in_valid = 1'b0;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(d_if.out_valid), 32'd0);
        cycles(2);
        chk("midrst_no_output", 32'(d_if.out_valid), 32'd0);
        send(16'h8001, 16'h8001, 1'b0, 32'h0, 1'b0);
        send(16'hAAAB, 16'h8001, 1'b0, 32'h0, 1'b1);
        cycles(4);
        chk("midrst_cnt", 32'(d_if.match_cnt), 32'd1);

        // Random traffic with all-EQ rules and random backpressure.
        d_if.cfg_rule = 32'h0; d_if.cfg_we = 1'b1; cycles(1); d_if.cfg_we = 1'b0;
        fork
            begin
                for (int c = 0; c < 80; c++) begin
                    d_if.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                d_if.out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    ra = 16'($urandom);
                    rb = ($urandom_range(0, 2) != 0) ? ra : ra ^ (16'h1 << $urandom_range(0, 15));
                    send(ra, rb, 1'b0, 32'h0, model_match(32'h0, ra, rb));
                end
            end
        join
        cycles(6);
        chk("random_sb_empty", 32'(sb.size()), 32'd0);

        // Saturation on the CNT_W=2 instance, then clear coinciding with a transfer.
        s_if.A = 16'hAAAB; s_if.B = 16'h8001; s_if.in_valid = 1'b1;
        cycles(5);
        s_if.in_valid = 1'b0;
        cycles(4);
        chk("sat_cnt", 32'(s_if.match_cnt), 32'd3);
        chk("sat_alarm", 32'(s_if.alarm), 32'd1);
        s_if.in_valid = 1'b1;
        cycles(1);
        s_if.in_valid = 1'b0;
        cycles(1);
        chk("sat_ov_before_clr", 32'(s_if.out_valid), 32'd1);
        s_if.clr_cnt = 1'b1;
        cycles(1);
        s_if.clr_cnt = 1'b0;
        chk("sat_clr_wins", 32'(s_if.match_cnt), 32'd0);
        chk("sat_consumed", 32'(s_if.out_valid), 32'd0);
`ifdef PROVA_STICKY_ALARM_EN
        chk("sat_alarm_after_clr", 32'(s_if.alarm), 32'd1);
`else
        chk("sat_alarm_after_clr", 32'(s_if.alarm), 32'd0);
`endif
        s_if.in_valid = 1'b1;
        cycles(1);
        s_if.in_valid = 1'b0;
        cycles(3);
        chk("sat_cnt_restart", 32'(s_if.match_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
